// File: rtl/hdmi_bringup_seq.sv
// rtl/hdmi_bringup_seq.sv - HDMI output path power-up and recovery sequencer
module hdmi_bringup_seq #(
    parameter int CNT_W         = 24,
    parameter int RST_CYCLES    = 10000,
    parameter int CFG_TIMEOUT   = 2000000,
    parameter int FRAME_TIMEOUT = 500000,
    parameter int RETRY_WAIT    = 100000,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pll_lock,
    input  logic       init_over,
    input  logic       vs_in,
    output logic       ctl_rstn,
    output logic       vid_rstn,
    output logic       led_ok,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_CFG    = 3'd2,
        S_VSTART = 3'd3,
        S_RUN    = 3'd4,
        S_RETRY  = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an interval of N cycles is N-1.
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CFG_END   = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RETRY_END = CNT_W'(RETRY_WAIT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    logic             lock_s1, lock_s2;
    logic             vs_s1, vs_s2, vs_s3;
    logic             vs_edge;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [3:0]       retry_q, retry_nxt;
    logic             fail;
    logic             cnt_clr;
    logic             ctl_nxt, vid_nxt, led_nxt, fault_nxt;

    // Input synchronizers; the vsync rise is captured into a pulse flop so
    // the FSM only ever sees a registered edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_s3   <= 1'b0;
            vs_edge <= 1'b0;
        end else begin
            lock_s1 <= pll_lock;
            lock_s2 <= lock_s1;
            vs_s1   <= vs_in;
            vs_s2   <= vs_s1;
            vs_s3   <= vs_s2;
            vs_edge <= vs_s2 & ~vs_s3;
        end
    end

    // Next-state, counter, retry and output decode.
    always_comb begin
        state_nxt = state_q;
        retry_nxt = retry_q;
        cnt_nxt   = cnt_q;
        fail      = 1'b0;
        cnt_clr   = 1'b0;

        if (!lock_s2 && state_q != S_FAULT) begin
            // Lock loss wins over everything and is not a retry.
            state_nxt = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_nxt = S_HOLD;
                S_HOLD:   if (cnt_q == HOLD_END) state_nxt = S_CFG;
                S_CFG: begin
                    // Success takes precedence over a timeout in the same cycle.
                    if (init_over)               state_nxt = S_VSTART;
                    else if (cnt_q == CFG_END)   fail = 1'b1;
                end
                S_VSTART: begin
                    if (vs_edge)                 state_nxt = S_RUN;
                    else if (cnt_q == FRAME_END) fail = 1'b1;
                end
                S_RUN: begin
                    // A frame arriving on the timeout cycle still counts.
                    if (!init_over)              fail = 1'b1;
                    else if (vs_edge)            cnt_clr = 1'b1;
                    else if (cnt_q == FRAME_END) fail = 1'b1;
                end
                S_RETRY:  if (cnt_q == RETRY_END) state_nxt = S_HOLD;
                S_FAULT:  state_nxt = S_FAULT;
                default:  state_nxt = S_IDLE;
            endcase

            if (fail) begin
                if (retry_q == RETRY_MAX) begin
                    state_nxt = S_FAULT;
                end else begin
                    retry_nxt = retry_q + 4'd1;
                    state_nxt = S_RETRY;
                end
            end
        end

        if (state_nxt != state_q || cnt_clr) begin
            cnt_nxt = '0;
        end else if (state_q inside {S_HOLD, S_CFG, S_VSTART, S_RUN, S_RETRY}) begin
            cnt_nxt = cnt_q + 1'b1;
        end

        ctl_nxt   = state_nxt inside {S_CFG, S_VSTART, S_RUN};
        vid_nxt   = state_nxt inside {S_VSTART, S_RUN};
        led_nxt   = (state_nxt == S_RUN);
        fault_nxt = (state_nxt == S_FAULT);
    end

    // State, counter and registered outputs, all loaded on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            retry_q  <= 4'd0;
            ctl_rstn <= 1'b0;
            vid_rstn <= 1'b0;
            led_ok   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            retry_q  <= retry_nxt;
            ctl_rstn <= ctl_nxt;
            vid_rstn <= vid_nxt;
            led_ok   <= led_nxt;
            fault    <= fault_nxt;
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hdmi_bringup_seq.sv
// tb/tb_hdmi_bringup_seq.sv - scoreboard bench for hdmi_bringup_seq
module tb_hdmi_bringup_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pll_lock;
    logic       init_over;
    logic       vs_in;
    logic       ctl_rstn, vid_rstn, led_ok, fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [10:0] obs_vec;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int          at;
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    hdmi_bringup_seq #(
        .CNT_W(24), .RST_CYCLES(10), .CFG_TIMEOUT(50),
        .FRAME_TIMEOUT(40), .RETRY_WAIT(8), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rstn(rstn), .pll_lock(pll_lock), .init_over(init_over),
        .vs_in(vs_in), .ctl_rstn(ctl_rstn), .vid_rstn(vid_rstn),
        .led_ok(led_ok), .fault(fault), .state(state), .retry_cnt(retry_cnt)
    );

    assign obs_vec = {state, retry_cnt, ctl_rstn, vid_rstn, led_ok, fault};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // {state, retry, ctl_rstn, vid_rstn, led_ok, fault}
    function automatic logic [10:0] mk(input int st, input int rc, input int ctl,
                                       input int vid, input int led, input int flt);
        return {3'(st), 4'(rc), 1'(ctl), 1'(vid), 1'(led), 1'(flt)};
    endfunction

    task automatic exp_at(input int at, input string tag, input logic [10:0] v);
        exp_t e;
        e.at  = at;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic goto_cyc(input int at);
        while (cyc < at) @(negedge clk);
    endtask

    // Compare every expectation that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check_eq(sb[i].tag, 32'(obs_vec), 32'(sb[i].v));
                sb.delete(i);
            end
        end
    end

    initial begin
        int t, v, v2, v3, k, r, c, x, y;
        rstn = 1'b0; pll_lock = 1'b0; init_over = 1'b0; vs_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", 32'(obs_vec), 32'd0);

        // Nominal bring-up
        rstn = 1'b1; pll_lock = 1'b1; t = cyc;
        exp_at(t + 2,  "idle_sync",  mk(0, 0, 0, 0, 0, 0));
        exp_at(t + 3,  "hold_entry", mk(1, 0, 0, 0, 0, 0));
        exp_at(t + 12, "hold_last",  mk(1, 0, 0, 0, 0, 0));
        exp_at(t + 13, "ctl_rise",   mk(2, 0, 1, 0, 0, 0));
        exp_at(t + 18, "cfg_wait",   mk(2, 0, 1, 0, 0, 0));
        exp_at(t + 19, "vid_rise",   mk(3, 0, 1, 1, 0, 0));
        goto_cyc(t + 18); init_over = 1'b1;
        v = t + 22;
        exp_at(v + 3, "vstart_wait", mk(3, 0, 1, 1, 0, 0));
        exp_at(v + 4, "run_entry",   mk(4, 0, 1, 1, 1, 0));
        goto_cyc(v); vs_in = 1'b1; goto_cyc(v + 2); vs_in = 1'b0;
        v2 = v + 30;
        exp_at(v2 + 4,  "run_frame2", mk(4, 0, 1, 1, 1, 0));
        exp_at(v2 + 20, "run_mid",    mk(4, 0, 1, 1, 1, 0));
        goto_cyc(v2); vs_in = 1'b1; goto_cyc(v2 + 2); vs_in = 1'b0;

        // Edge coincident with the last count in RUN
        v3 = v2 + 40;
        exp_at(v3 + 3, "run_cnt39",    mk(4, 0, 1, 1, 1, 0));
        exp_at(v3 + 4, "edge_vs_tmo",  mk(4, 0, 1, 1, 1, 0));
        exp_at(v3 + 5, "run_after",    mk(4, 0, 1, 1, 1, 0));
        goto_cyc(v3); vs_in = 1'b1; goto_cyc(v3 + 2); vs_in = 1'b0;

        // Frame loss
        k = v3 + 4;
        exp_at(k + 39, "run_pre_loss", mk(4, 0, 1, 1, 1, 0));
        exp_at(k + 40, "frame_loss",   mk(5, 1, 0, 0, 0, 0));
        goto_cyc(k + 40); init_over = 1'b0;
        r = k + 40;
        exp_at(r + 7,  "retry_last", mk(5, 1, 0, 0, 0, 0));
        exp_at(r + 8,  "retry_hold", mk(1, 1, 0, 0, 0, 0));
        exp_at(r + 17, "hold2_last", mk(1, 1, 0, 0, 0, 0));
        exp_at(r + 18, "cfg2",       mk(2, 1, 1, 0, 0, 0));

        // init_over arriving on the CFG timeout cycle
        c = r + 18;
        exp_at(c + 49, "cfg_cnt49",   mk(2, 1, 1, 0, 0, 0));
        exp_at(c + 50, "cfg_late_ok", mk(3, 1, 1, 1, 0, 0));
        exp_at(c + 51, "vstart2",     mk(3, 1, 1, 1, 0, 0));
        goto_cyc(c + 49); init_over = 1'b1;

        // Lock loss in VSTART
        x = c + 51;
        exp_at(x + 2, "lock_sync",  mk(3, 1, 1, 1, 0, 0));
        exp_at(x + 3, "lock_lost",  mk(0, 1, 0, 0, 0, 0));
        goto_cyc(x); pll_lock = 1'b0; init_over = 1'b0;
        y = x + 5;
        exp_at(y + 3,  "relock_hold", mk(1, 1, 0, 0, 0, 0));
        exp_at(y + 12, "relock_last", mk(1, 1, 0, 0, 0, 0));
        exp_at(y + 13, "relock_cfg",  mk(2, 1, 1, 0, 0, 0));
        exp_at(y + 16, "vstart3",     mk(3, 1, 1, 1, 0, 0));
        exp_at(y + 22, "run2",        mk(4, 1, 1, 1, 1, 0));
        goto_cyc(y); pll_lock = 1'b1;
        goto_cyc(y + 15); init_over = 1'b1;
        goto_cyc(y + 18); vs_in = 1'b1; goto_cyc(y + 20); vs_in = 1'b0;

        // Asynchronous reset mid-frame
        goto_cyc(y + 30);
        #2 rstn = 1'b0;
        #1 check_eq("async_rst", 32'(obs_vec), 32'd0);
        @(negedge clk);
        @(negedge clk);
        init_over = 1'b0;

        // Config timeouts into FAULT
        rstn = 1'b1; c = cyc;
        exp_at(c + 3,   "t_hold",     mk(1, 0, 0, 0, 0, 0));
        exp_at(c + 13,  "t_cfg",      mk(2, 0, 1, 0, 0, 0));
        exp_at(c + 62,  "t_cfg49",    mk(2, 0, 1, 0, 0, 0));
        exp_at(c + 63,  "t_retry1",   mk(5, 1, 0, 0, 0, 0));
        exp_at(c + 70,  "t_retry1_l", mk(5, 1, 0, 0, 0, 0));
        exp_at(c + 71,  "t_hold1",    mk(1, 1, 0, 0, 0, 0));
        exp_at(c + 81,  "t_cfg1",     mk(2, 1, 1, 0, 0, 0));
        exp_at(c + 130, "t_cfg1_l",   mk(2, 1, 1, 0, 0, 0));
        exp_at(c + 131, "t_retry2",   mk(5, 2, 0, 0, 0, 0));
        exp_at(c + 139, "t_hold2",    mk(1, 2, 0, 0, 0, 0));
        exp_at(c + 149, "t_cfg2",     mk(2, 2, 1, 0, 0, 0));
        exp_at(c + 198, "t_cfg2_l",   mk(2, 2, 1, 0, 0, 0));
        exp_at(c + 199, "t_fault",    mk(6, 2, 0, 0, 0, 1));
        exp_at(c + 220, "fault_nolk", mk(6, 2, 0, 0, 0, 1));
        exp_at(c + 230, "fault_stay", mk(6, 2, 0, 0, 0, 1));
        goto_cyc(c + 210); pll_lock = 1'b0;
        goto_cyc(c + 225); init_over = 1'b1;
        goto_cyc(c + 235);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
